// File: rtl/ceu_div_pkg.sv
// Shared types and the round-robin pick helper for the CEU divider arbiter.
package ceu_div_pkg;

    localparam int unsigned DBL_WIDTH = 64;
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned PICK_W    = 3;

    typedef logic [63:0] dbl_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } arb_state_e;

    // First set bit of req at or after ptr, wrapping modulo n; 0 when req is empty.
    function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [PICK_W-1:0]  ptr,
                                                  input int unsigned        n);
        logic [PICK_W-1:0] pick;
        logic              found;
        int unsigned       idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % n;
            if (!found && (k < n) && req[PICK_W'(idx)]) begin
                pick  = PICK_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ceu_div_arbiter_tag_fifo.sv
// In-order requester tag FIFO tracking divides outstanding in the shared divider.
module ceu_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rd_data_c,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, full_q, push_ok, pop_ok;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is accepted only when a pop frees the head slot.
    always_comb begin
        pop_ok  = pop_i && !empty_q;
        push_ok = push_i && (!full_q || pop_ok);
        wr_d    = push_ok ? nxt(wr_q) : wr_q;
        rd_d    = pop_ok ? nxt(rd_q) : rd_q;
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    assign rd_data_c = mem_q[rd_q];
    assign empty_o   = empty_q;
    assign full_o    = full_q;
    assign count_o   = count_q;

endmodule

// File: rtl/ceu_div_arbiter.sv
// Round-robin arbiter sharing one pipelined FP64 divider across CEU requesters.
// Optional statistics counters are enabled with CEU_DIV_ARB_STATS_EN.
module ceu_div_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DBL_WIDTH    = ceu_div_pkg::DBL_WIDTH,
    parameter int unsigned MAX_INFLIGHT = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DBL_WIDTH-1:0]   req_num,
    input  logic [NUM_REQ*DBL_WIDTH-1:0]   req_den,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [DBL_WIDTH-1:0]           resp_quot,
    output logic                           div_valid,
    output logic [DBL_WIDTH-1:0]           div_numerator,
    output logic [DBL_WIDTH-1:0]           div_denominator,
    input  logic                           div_finish,
    input  logic [DBL_WIDTH-1:0]           div_quotient,
    input  logic                           drain_req,
    output logic                           drain_done,
    output logic                           busy,
    output logic                           err_orphan
`ifdef CEU_DIV_ARB_STATS_EN
    ,
    output logic [31:0]                    stat_issued,
    output logic [31:0]                    stat_full_stall,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] stat_max_inflight
`endif
);
    import ceu_div_pkg::*;

    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d, pick, pop_tag;
    logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
    logic [DBL_WIDTH-1:0]   resp_quot_q, resp_quot_d;
    logic [DBL_WIDTH-1:0]   num_q, num_d, den_q, den_d;
    logic                   div_valid_q, drain_done_q, busy_q, err_orphan_q, err_orphan_d;
    logic                   grant, pop, orphan, fifo_empty, fifo_full;
    logic [CNT_W-1:0]       inflight, inflight_d;

    ceu_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (grant),
        .data_i    (pick),
        .pop_i     (pop),
        .rd_data_c (pop_tag),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (inflight)
    );

    // Grant, issue, return and drain-FSM next state; rst_n gates the combinational grant.
    always_comb begin
        pop          = div_finish && !fifo_empty;
        orphan       = div_finish && fifo_empty;
        pick         = ID_W'(rr_pick(MAX_REQ'(req_valid), PICK_W'(ptr_q), NUM_REQ));
        grant        = rst_n && (state_q == RUN) && (|req_valid) && (!fifo_full || pop);
        req_ready    = '0;
        ptr_d        = ptr_q;
        num_d        = num_q;
        den_d        = den_q;
        resp_valid_d = '0;
        resp_quot_d  = resp_quot_q;
        err_orphan_d = err_orphan_q | orphan;
        inflight_d   = inflight + CNT_W'(grant) - CNT_W'(pop);
        state_d      = state_q;

        if (grant) begin
            req_ready[pick] = 1'b1;
            ptr_d = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
            num_d = req_num[pick*DBL_WIDTH +: DBL_WIDTH];
            den_d = req_den[pick*DBL_WIDTH +: DBL_WIDTH];
        end
        if (pop) begin
            resp_valid_d[pop_tag] = 1'b1;
            resp_quot_d           = div_quotient;
        end

        case (state_q)
            RUN:     if (drain_req) state_d = DRAIN;
            DRAIN: begin
                if (!drain_req)               state_d = RUN;
                else if (inflight_d == '0)    state_d = DRAINED;
            end
            DRAINED: if (!drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            ptr_q        <= '0;
            resp_valid_q <= '0;
            resp_quot_q  <= '0;
            div_valid_q  <= 1'b0;
            num_q        <= '0;
            den_q        <= '0;
            drain_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_quot_q  <= resp_quot_d;
            div_valid_q  <= grant;
            num_q        <= num_d;
            den_q        <= den_d;
            drain_done_q <= (state_d == DRAINED);
            busy_q       <= (inflight_d != '0);
            err_orphan_q <= err_orphan_d;
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_quot       = resp_quot_q;
    assign div_valid       = div_valid_q;
    assign div_numerator   = num_q;
    assign div_denominator = den_q;
    assign drain_done      = drain_done_q;
    assign busy            = busy_q;
    assign err_orphan      = err_orphan_q;

`ifdef CEU_DIV_ARB_STATS_EN
    logic [31:0]      issued_q, stall_q;
    logic [CNT_W-1:0] hwm_q;
    logic             full_stall;

    assign full_stall = (state_q == RUN) && (|req_valid) && fifo_full && !pop;

    // Saturating counters; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            stall_q  <= '0;
            hwm_q    <= '0;
        end else begin
            if (grant && (issued_q != '1))     issued_q <= issued_q + 32'd1;
            if (full_stall && (stall_q != '1)) stall_q  <= stall_q + 32'd1;
            if (inflight_d > hwm_q)            hwm_q    <= inflight_d;
        end
    end

    assign stat_issued       = issued_q;
    assign stat_full_stall   = stall_q;
    assign stat_max_inflight = hwm_q;
`endif

endmodule
